// File: rtl/sdram_arbiter_if.sv
// Bundle of the three requester ports and the SDRAM controller port that
// meet at the arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the requesters and controller.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 26
);
  // VGA scan-out reader
  logic              vga_request;
  logic [ADDR_W-1:0] vga_address;
  logic              vga_ack;
  logic              vga_valid;
  logic [31:0]       vga_rdata;
  logic              vga_complete;

  // CPU data port
  logic              cpu_request;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_ack;
  logic              cpu_valid;
  logic [31:0]       cpu_rdata;
  logic              cpu_complete;

  // Blitter
  logic              blit_request;
  logic              blit_write;
  logic [ADDR_W-1:0] blit_address;
  logic [31:0]       blit_wdata;
  logic [3:0]        blit_wstrb;
  logic              blit_ack;
  logic              blit_valid;
  logic [31:0]       blit_rdata;
  logic              blit_complete;

  // SDRAM controller command/response port
  logic              sdram_request;
  logic              sdram_write;
  logic [ADDR_W-1:0] sdram_address;
  logic [31:0]       sdram_wdata;
  logic [3:0]        sdram_wstrb;
  logic [5:0]        sdram_burst;
  logic              sdram_ack;
  logic              sdram_valid;
  logic [31:0]       sdram_rdata;
  logic              sdram_complete;

  modport slave (
    input  vga_request, vga_address,
    output vga_ack, vga_valid, vga_rdata, vga_complete,
    input  cpu_request, cpu_write, cpu_address, cpu_wdata, cpu_wstrb,
    output cpu_ack, cpu_valid, cpu_rdata, cpu_complete,
    input  blit_request, blit_write, blit_address, blit_wdata, blit_wstrb,
    output blit_ack, blit_valid, blit_rdata, blit_complete,
    output sdram_request, sdram_write, sdram_address, sdram_wdata,
           sdram_wstrb, sdram_burst,
    input  sdram_ack, sdram_valid, sdram_rdata, sdram_complete
  );

  modport master (
    output vga_request, vga_address,
    input  vga_ack, vga_valid, vga_rdata, vga_complete,
    output cpu_request, cpu_write, cpu_address, cpu_wdata, cpu_wstrb,
    input  cpu_ack, cpu_valid, cpu_rdata, cpu_complete,
    output blit_request, blit_write, blit_address, blit_wdata, blit_wstrb,
    input  blit_ack, blit_valid, blit_rdata, blit_complete,
    input  sdram_request, sdram_write, sdram_address, sdram_wdata,
           sdram_wstrb, sdram_burst,
    output sdram_ack, sdram_valid, sdram_rdata, sdram_complete
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between the VGA reader, the CPU and the
// blitter. VGA has fixed priority; CPU and blitter alternate round-robin.
// The winning command is registered onto the controller port and the
// controller's strobes are routed back to the owner only.
//
// state | meaning
// IDLE  | no owner; arbitrate and capture the winner's command
// REQ   | command presented on sdram_*, waiting for sdram_ack
// DATA  | command accepted, waiting for sdram_complete
module sdram_arbiter #(
  parameter int VGA_BURST = 32,
  parameter int ADDR_W    = 26
) (
  input  logic            clock,
  input  logic            resetn,
  sdram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU, OWN_BLIT} owner_t;

  localparam logic [5:0] BURST_VGA = 6'(VGA_BURST);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  // 1 = blitter was granted last, so the CPU wins the next tie
  logic              last_rr_q, last_rr_d;
  logic              req_q, req_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [5:0]        burst_q, burst_d;

  logic in_req;
  logic busy;

  // State, owner and captured command registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      last_rr_q <= 1'b1;
      req_q     <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_rr_q <= last_rr_d;
      req_q     <= req_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      burst_q   <= burst_d;
    end
  end

  // Arbitration, command capture and transaction sequencing
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_rr_d = last_rr_q;
    req_d     = req_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    burst_d   = burst_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.vga_request) begin
          owner_d = OWN_VGA;
          req_d   = 1'b1;
          write_d = 1'b0;
          addr_d  = bus.vga_address;
          wdata_d = '0;
          wstrb_d = 4'hF;
          burst_d = BURST_VGA;
          state_d = ST_REQ;
        end else if (bus.cpu_request && (!bus.blit_request || last_rr_q)) begin
          owner_d   = OWN_CPU;
          last_rr_d = 1'b0;
          req_d     = 1'b1;
          write_d   = bus.cpu_write;
          addr_d    = bus.cpu_address;
          wdata_d   = bus.cpu_wdata;
          wstrb_d   = bus.cpu_wstrb;
          burst_d   = 6'd1;
          state_d   = ST_REQ;
        end else if (bus.blit_request) begin
          owner_d   = OWN_BLIT;
          last_rr_d = 1'b1;
          req_d     = 1'b1;
          write_d   = bus.blit_write;
          addr_d    = bus.blit_address;
          wdata_d   = bus.blit_wdata;
          wstrb_d   = bus.blit_wstrb;
          burst_d   = 6'd1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        // The command is committed: a dropped request does not abort it.
        if (bus.sdram_ack) begin
          req_d = 1'b0;
          if (bus.sdram_complete) begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bus.sdram_complete) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign in_req = (state_q == ST_REQ);
  assign busy   = (state_q != ST_IDLE);

  assign bus.sdram_request = req_q;
  assign bus.sdram_write   = write_q;
  assign bus.sdram_address = addr_q;
  assign bus.sdram_wdata   = wdata_q;
  assign bus.sdram_wstrb   = wstrb_q;
  assign bus.sdram_burst   = burst_q;

  // Strobes reach only the owner, with no added latency
  always_comb begin
    bus.vga_ack       = in_req && (owner_q == OWN_VGA)  && bus.sdram_ack;
    bus.cpu_ack       = in_req && (owner_q == OWN_CPU)  && bus.sdram_ack;
    bus.blit_ack      = in_req && (owner_q == OWN_BLIT) && bus.sdram_ack;
    bus.vga_valid     = busy && (owner_q == OWN_VGA)  && bus.sdram_valid;
    bus.cpu_valid     = busy && (owner_q == OWN_CPU)  && bus.sdram_valid;
    bus.blit_valid    = busy && (owner_q == OWN_BLIT) && bus.sdram_valid;
    bus.vga_complete  = busy && (owner_q == OWN_VGA)  && bus.sdram_complete;
    bus.cpu_complete  = busy && (owner_q == OWN_CPU)  && bus.sdram_complete;
    bus.blit_complete = busy && (owner_q == OWN_BLIT) && bus.sdram_complete;
  end

  assign bus.vga_rdata  = bus.sdram_rdata;
  assign bus.cpu_rdata  = bus.sdram_rdata;
  assign bus.blit_rdata = bus.sdram_rdata;

endmodule
